// File: rtl/core_run_ctrl.sv
// Run/debug sequencer: streams a program into IMEM, then gates the core via run/step/halt.
// Latency: IMEM write and state update on the accepting edge; backpressure: load_ready low in RUN/STEP.
module core_run_ctrl #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8,
    parameter int MAX_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic [31:0]       instruction,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              core_en,
    output logic [2:0]        state,
    output logic [1:0]        halt_cause,
    output logic              load_trunc,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    localparam logic [31:0]       EBREAK_INSN = 32'h0010_0073;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [31:0]       WD_LIMIT    = 32'(MAX_CYCLES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic [1:0]        halt_cause_q, halt_cause_d;
    logic              load_trunc_q, load_trunc_d;

    logic              ebreak_hit;
    logic              accept;
    logic              new_prog;
    logic [31:0]       cnt_inc;
    logic              wd_hit;

    assign ebreak_hit = (instruction == EBREAK_INSN);
    assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                        (state_q == S_READY) || (state_q == S_HALT);
    assign accept     = load_valid && load_ready;
    // Any accept outside LOAD begins a fresh program at address 0.
    assign new_prog   = accept && (state_q != S_LOAD);

    assign imem_we    = accept;
    assign imem_waddr = new_prog ? '0 : wcnt_q;
    assign imem_wdata = load_data;

    assign core_rst_n = !((state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_READY));
    assign core_en    = ((state_q == S_RUN) || (state_q == S_STEP)) && !ebreak_hit;

    assign cnt_inc    = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
    // Compare with >= so a resume past the budget halts again after one cycle.
    assign wd_hit     = (MAX_CYCLES != 0) && core_en && (cnt_inc >= WD_LIMIT);

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        cycle_count_d = core_en ? cnt_inc : cycle_count_q;
        halt_cause_d  = halt_cause_q;
        load_trunc_d  = load_trunc_q;

        if (accept) begin
            wcnt_d  = imem_waddr + 1'b1;
            state_d = S_LOAD;
            if (new_prog) begin
                cycle_count_d = '0;
                halt_cause_d  = 2'd0;
                load_trunc_d  = 1'b0;
            end
            if (load_last || (imem_waddr == LAST_ADDR)) begin
                state_d      = S_READY;
                load_trunc_d = !load_last;
            end
        end else begin
            case (state_q)
                S_READY, S_HALT: begin
                    if (run_req) begin
                        state_d      = S_RUN;
                        halt_cause_d = 2'd0;
                    end else if (step_req) begin
                        state_d      = S_STEP;
                        halt_cause_d = 2'd0;
                    end
                end
                S_RUN: begin
                    if (ebreak_hit) begin
                        state_d      = S_HALT;
                        halt_cause_d = 2'd2;
                    end else if (wd_hit) begin
                        state_d      = S_HALT;
                        halt_cause_d = 2'd3;
                    end else if (halt_req) begin
                        state_d      = S_HALT;
                        halt_cause_d = 2'd1;
                    end
                end
                S_STEP: begin
                    state_d      = S_HALT;
                    halt_cause_d = ebreak_hit ? 2'd2 : 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wcnt_q        <= '0;
            cycle_count_q <= '0;
            halt_cause_q  <= 2'd0;
            load_trunc_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            cycle_count_q <= cycle_count_d;
            halt_cause_q  <= halt_cause_d;
            load_trunc_q  <= load_trunc_d;
        end
    end

    assign state       = state_q;
    assign halt_cause  = halt_cause_q;
    assign load_trunc  = load_trunc_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a tiny IMEM + PC model standing in for the core.
module tb_core_run_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] JAL0   = 32'h0000_006F;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        run_req;
    logic        step_req;
    logic        halt_req;
    logic [31:0] instruction;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        core_en;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic        load_trunc;
    logic [31:0] cycle_count;

    int n_assert = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int en0;

    logic [31:0] mem [256];
    logic [7:0]  pc;

    core_run_ctrl #(.IMEM_DEPTH(256), .ADDR_W(8), .MAX_CYCLES(10)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready),
        .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .instruction(instruction),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .core_en(core_en), .state(state),
        .halt_cause(halt_cause), .load_trunc(load_trunc), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal core: PC advances on each commit, jal x0,0 spins in place.
    always @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
        if (!core_rst_n) pc <= 8'd0;
        else if (core_en && instruction != JAL0) pc <= pc + 8'd1;
        if (core_en) en_cnt <= en_cnt + 1;
    end
    assign instruction = mem[pc];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [7:0] exp_addr);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        #1;
        chk("load_we", {31'd0, imem_we}, 32'd1);
        chk("load_addr", {24'd0, imem_waddr}, {24'd0, exp_addr});
        chk("load_wdata", imem_wdata, d);
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("rst_core_en", {31'd0, core_en}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_halt_cause", {30'd0, halt_cause}, 32'd0);
        rst = 1'b0;

        // Program 1: NOP x3 then EBREAK.
        send(NOP, 1'b0, 8'd0);
        send(NOP, 1'b0, 8'd1);
        send(NOP, 1'b0, 8'd2);
        send(EBREAK, 1'b1, 8'd3);
        @(negedge clk); load_valid = 1'b0;
        chk("p1_state_ready", {29'd0, state}, 32'd2);
        chk("p1_trunc", {31'd0, load_trunc}, 32'd0);
        chk("p1_core_rst_n", {31'd0, core_rst_n}, 32'd0);

        run_req = 1'b1;
        @(negedge clk); run_req = 1'b0;
        chk("run_state", {29'd0, state}, 32'd3);
        chk("run_core_en", {31'd0, core_en}, 32'd1);
        chk("run_load_ready", {31'd0, load_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("ebreak_core_en", {31'd0, core_en}, 32'd0);
        chk("ebreak_cnt", cycle_count, 32'd3);
        @(negedge clk);
        chk("ebreak_state", {29'd0, state}, 32'd5);
        chk("ebreak_cause", {30'd0, halt_cause}, 32'd2);
        chk("halt_core_rst_n", {31'd0, core_rst_n}, 32'd1);

        // Resume onto EBREAK with halt_req also high: zero commits, cause 2.
        run_req = 1'b1; halt_req = 1'b1;
        @(negedge clk); run_req = 1'b0;
        chk("resume_state", {29'd0, state}, 32'd3);
        chk("resume_cause_clr", {30'd0, halt_cause}, 32'd0);
        chk("resume_core_en", {31'd0, core_en}, 32'd0);
        @(negedge clk);
        chk("resume_rehalt", {29'd0, state}, 32'd5);
        chk("resume_cause", {30'd0, halt_cause}, 32'd2);
        chk("resume_cnt", cycle_count, 32'd3);

        step_req = 1'b1;
        @(negedge clk); step_req = 1'b0;
        chk("step_eb_state", {29'd0, state}, 32'd4);
        chk("step_eb_core_en", {31'd0, core_en}, 32'd0);
        @(negedge clk); halt_req = 1'b0;
        chk("step_eb_cause", {30'd0, halt_cause}, 32'd2);

        // Program 2: NOP x3 then an infinite loop.
        send(NOP, 1'b0, 8'd0);
        send(NOP, 1'b0, 8'd1);
        chk("p2_state_load", {29'd0, state}, 32'd1);
        chk("p2_cnt_clr", cycle_count, 32'd0);
        chk("p2_cause_clr", {30'd0, halt_cause}, 32'd0);
        send(NOP, 1'b0, 8'd2);
        send(JAL0, 1'b1, 8'd3);
        @(negedge clk); load_valid = 1'b0;
        chk("p2_state_ready", {29'd0, state}, 32'd2);

        step_req = 1'b1;
        @(negedge clk); step_req = 1'b0;
        chk("step1_state", {29'd0, state}, 32'd4);
        chk("step1_core_en", {31'd0, core_en}, 32'd1);
        @(negedge clk);
        chk("step1_halt", {29'd0, state}, 32'd5);
        chk("step1_cause", {30'd0, halt_cause}, 32'd1);
        chk("step1_cnt", cycle_count, 32'd1);

        en0 = en_cnt;
        step_req = 1'b1;
        @(negedge clk);
        chk("step3_a", {29'd0, state}, 32'd4);
        @(negedge clk);
        chk("step3_b", {29'd0, state}, 32'd5);
        @(negedge clk); step_req = 1'b0;
        chk("step3_c", {29'd0, state}, 32'd4);
        @(negedge clk);
        chk("step3_d", {29'd0, state}, 32'd5);
        chk("step3_en_cycles", en_cnt - en0, 32'd2);
        chk("step3_cnt", cycle_count, 32'd3);

        run_req = 1'b1;
        @(negedge clk); run_req = 1'b0;
        chk("run2_state", {29'd0, state}, 32'd3);
        @(negedge clk); halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
        chk("hreq_state", {29'd0, state}, 32'd5);
        chk("hreq_cause", {30'd0, halt_cause}, 32'd1);
        chk("hreq_cnt", cycle_count, 32'd5);

        run_req = 1'b1;
        @(negedge clk); run_req = 1'b0;
        for (int k = 0; k < 40 && state != 3'd5; k++) @(negedge clk);
        chk("wd_state", {29'd0, state}, 32'd5);
        chk("wd_cause", {30'd0, halt_cause}, 32'd3);
        chk("wd_cnt", cycle_count, 32'd10);

        en0 = en_cnt;
        run_req = 1'b1;
        @(negedge clk); run_req = 1'b0;
        chk("wd2_core_en", {31'd0, core_en}, 32'd1);
        @(negedge clk);
        chk("wd2_state", {29'd0, state}, 32'd5);
        chk("wd2_cause", {30'd0, halt_cause}, 32'd3);
        chk("wd2_cnt", cycle_count, 32'd11);
        chk("wd2_en_cycles", en_cnt - en0, 32'd1);

        // Fill IMEM without load_last.
        for (int i = 0; i < 256; i++) begin
            send(32'(i), 1'b0, 8'(i));
            if (i == 255) chk("trunc_pre_state", {29'd0, state}, 32'd1);
        end
        @(negedge clk); load_valid = 1'b0;
        chk("trunc_state", {29'd0, state}, 32'd2);
        chk("trunc_flag", {31'd0, load_trunc}, 32'd1);
        chk("trunc_load_ready", {31'd0, load_ready}, 32'd1);
        send(JAL0, 1'b0, 8'd0);
        send(NOP, 1'b1, 8'd1);
        chk("trunc_clr", {31'd0, load_trunc}, 32'd0);
        @(negedge clk); load_valid = 1'b0;
        chk("p3_state_ready", {29'd0, state}, 32'd2);

        run_req = 1'b1;
        @(negedge clk); run_req = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("p3_run_cnt", cycle_count, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", {29'd0, state}, 32'd0);
        chk("arst_core_en", {31'd0, core_en}, 32'd0);
        chk("arst_cnt", cycle_count, 32'd0);
        chk("arst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        @(negedge clk); rst = 1'b0;
        send(NOP, 1'b1, 8'd0);
        @(negedge clk); load_valid = 1'b0;
        chk("reload_state", {29'd0, state}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
